// File: rtl/lcd_write_sequencer.sv
// rtl/lcd_write_sequencer.sv - HD44780 character LCD write sequencer
// Runs power-up wait and init ROM, then strobes one handshaked byte at a time.
module lcd_write_sequencer #(
  parameter int unsigned POWERUP_CYC   = 750000,
  parameter int unsigned SETUP_CYC     = 3,
  parameter int unsigned PULSE_CYC     = 12,
  parameter int unsigned HOLD_CYC      = 2,
  parameter int unsigned EXEC_CYC      = 2500,
  parameter int unsigned LONG_EXEC_CYC = 100000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_vld,
  input  logic       i_req_rs,
  input  logic [7:0] i_req_data,
  output logic       o_req_rdy,
  output logic       o_init_done,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic       o_lcd_on
);

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAX_CYC = umax(umax(umax(POWERUP_CYC, SETUP_CYC), umax(PULSE_CYC, HOLD_CYC)),
                                         umax(EXEC_CYC, LONG_EXEC_CYC));
  localparam int unsigned CW = $clog2(MAX_CYC) + 1;

  if (POWERUP_CYC < 1 || SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1 ||
      EXEC_CYC < 1 || LONG_EXEC_CYC < 1) begin : g_param_check
    $error("lcd_write_sequencer: every cycle parameter must be >= 1");
  end

  typedef enum logic [2:0] {
    PWRUP, INIT_ISSUE, SETUP, PULSE, HOLD, WAIT, IDLE
  } state_t;

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: return 8'h38;
      3'd3:             return 8'h0C;
      3'd4:             return 8'h01;
      default:          return 8'h06;
    endcase
  endfunction

  // Clear (0x01) and home (0x02/0x03) need the long execution time.
  function automatic logic is_long(input logic rs, input logic [7:0] d);
    return !rs && (d[7:2] == 6'd0) && (d != 8'd0);
  endfunction

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    init_idx;
  logic          wait_long;
  logic [CW-1:0] wait_len;
  logic          write_done;

  assign wait_len = wait_long ? CW'(LONG_EXEC_CYC) : CW'(EXEC_CYC);

  // The last wait cycle is spent in IDLE/INIT_ISSUE so the next latch lands
  // exactly at the end of the occupancy window, with no extra bubble.
  assign write_done = ((state == HOLD) && (cnt == CW'(HOLD_CYC - 1)) && (wait_len == CW'(1))) ||
                      ((state == WAIT) && (cnt == wait_len - CW'(2)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= PWRUP;
      cnt         <= '0;
      init_idx    <= 3'd0;
      wait_long   <= 1'b0;
      o_req_rdy   <= 1'b0;
      o_init_done <= 1'b0;
      o_lcd_data  <= 8'h00;
      o_lcd_rs    <= 1'b0;
      o_lcd_rw    <= 1'b0;
      o_lcd_en    <= 1'b0;
      o_lcd_on    <= 1'b0;
    end else begin
      o_lcd_on <= 1'b1;
      o_lcd_rw <= 1'b0;
      case (state)
        PWRUP: begin
          if (cnt == CW'(POWERUP_CYC - 1)) begin
            state <= INIT_ISSUE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        INIT_ISSUE: begin
          o_lcd_data <= init_rom(init_idx);
          o_lcd_rs   <= 1'b0;
          wait_long  <= is_long(1'b0, init_rom(init_idx));
          init_idx   <= init_idx + 3'd1;
          state      <= SETUP;
          cnt        <= '0;
        end
        IDLE: begin
          if (i_req_vld) begin
            o_lcd_data <= i_req_data;
            o_lcd_rs   <= i_req_rs;
            wait_long  <= is_long(i_req_rs, i_req_data);
            o_req_rdy  <= 1'b0;
            state      <= SETUP;
            cnt        <= '0;
          end
        end
        SETUP: begin
          if (cnt == CW'(SETUP_CYC - 1)) begin
            o_lcd_en <= 1'b1;
            state    <= PULSE;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PULSE: begin
          if (cnt == CW'(PULSE_CYC - 1)) begin
            o_lcd_en <= 1'b0;
            state    <= HOLD;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          if (cnt == CW'(HOLD_CYC - 1)) begin
            state <= WAIT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT: begin
          cnt <= cnt + CW'(1);
        end
        default: begin
          state <= PWRUP;
          cnt   <= '0;
        end
      endcase

      if (write_done) begin
        cnt <= '0;
        if (!o_init_done && (init_idx != 3'd6)) begin
          state <= INIT_ISSUE;
        end else begin
          state       <= IDLE;
          o_req_rdy   <= 1'b1;
          o_init_done <= 1'b1;
        end
      end
    end
  end

endmodule
